sequence_stepper: RTL and testbench

Controller that drives the 4-bit `value` input of the seven-segment display block with a programmable, non-sequential count. It holds an 8-entry sequence table and steps through it at a divided tick rate. It supports run, pause, single-step and stop, and signals each sequence wrap. It sits between board buttons/switches and the display driver.

---
 rtl/sequence_stepper_if.sv | 29 ++
 rtl/sequence_stepper.sv | 164 ++++++++++++++++
 tb/tb_sequence_stepper.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_stepper_if.sv
// sequence_stepper_if: control pulses, table write port and display-side
// outputs of the sequence stepper, bundled for a single port connection.
interface sequence_stepper_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic       step;
  logic       dir;
  logic [2:0] seq_len;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] value;
  logic [2:0] index;
  logic       running;
  logic       wrap;

  // Board side: buttons, switches and table loader.
  modport master (
    output start, pause, stop, step, dir, seq_len, wr_en, wr_addr, wr_data,
    input  value, index, running, wrap
  );

  // Stepper side.
  modport slave (
    input  start, pause, stop, step, dir, seq_len, wr_en, wr_addr, wr_data,
    output value, index, running, wrap
  );
endinterface

// File: rtl/sequence_stepper.sv
// sequence_stepper: steps a display value through a programmable 8-entry
// table at a divided tick rate, with run / pause / single-step / stop.
// Optional feature: define SEQ_REVERSE_EN to let `dir` select down-counting.
module sequence_stepper #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input logic               clk,
  input logic               rst_n,
  sequence_stepper_if.slave bus
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned IDX_W = 3;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEPTH*VAL_W-1:0] TBL_INIT =
    {4'hA, 4'h6, 4'hF, 4'hC, 4'h9, 4'h5, 4'h3, 4'h0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   index_q;
  logic [IDX_W-1:0]   len_q;
  logic [VAL_W-1:0]   value_q;
  logic               running_q;
  logic               wrap_q;
  logic [DIV_W-1:0]   div_q;
  logic [VAL_W-1:0]   seq_tbl [DEPTH];

  logic               cmd_stop;
  logic               cmd_pause;
  logic               cmd_start;
  logic               cmd_step;
  logic               tick;
  logic               do_adv;
  logic               adv_down;
  logic [IDX_W-1:0]   adv_idx;
  logic               adv_wrap;
  logic               wr_ok;
  logic [IDX_W-1:0]   idx_nxt;
  logic [VAL_W-1:0]   val_nxt;

`ifdef SEQ_REVERSE_EN
  assign adv_down = bus.dir;
`else
  logic unused_dir;
  assign adv_down   = 1'b0;
  assign unused_dir = bus.dir;
`endif

  // Only the highest-priority pulse in a cycle is acted on.
  always_comb begin
    cmd_stop  = bus.stop;
    cmd_pause = !bus.stop && bus.pause;
    cmd_start = !bus.stop && !bus.pause && bus.start;
    cmd_step  = !bus.stop && !bus.pause && !bus.start && bus.step;
  end

  // Candidate next index for one advance, and whether it wraps.
  always_comb begin
    adv_idx  = index_q;
    adv_wrap = 1'b0;
    if (adv_down) begin
      adv_wrap = (index_q == '0);
      adv_idx  = adv_wrap ? len_q : IDX_W'(index_q - IDX_W'(1));
    end else begin
      adv_wrap = (index_q == len_q);
      adv_idx  = adv_wrap ? '0 : IDX_W'(index_q + IDX_W'(1));
    end
  end

  // Decide this edge's index and the value that will sit beside it.
  always_comb begin
    tick    = (state == S_RUN) && (div_q == DIV_LAST);
    do_adv  = ((state == S_RUN) && !cmd_stop && !cmd_pause && tick) ||
              ((state == S_HOLD) && cmd_step);
    wr_ok   = bus.wr_en && (state != S_RUN);
    idx_nxt = index_q;
    if (cmd_stop) begin
      idx_nxt = '0;
    end else if (do_adv) begin
      idx_nxt = adv_idx;
    end
    // A same-cycle write to the destination entry must be visible at once.
    if (wr_ok && (bus.wr_addr == idx_nxt)) begin
      val_nxt = bus.wr_data;
    end else begin
      val_nxt = seq_tbl[idx_nxt];
    end
  end

  // Mode FSM, divider, table and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      index_q   <= '0;
      value_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      len_q     <= IDX_W'(DEPTH - 1);
      div_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        seq_tbl[i] <= TBL_INIT[i*VAL_W +: VAL_W];
      end
    end else begin
      index_q <= idx_nxt;
      value_q <= val_nxt;
      wrap_q  <= do_adv && adv_wrap;
      if (wr_ok) begin
        seq_tbl[bus.wr_addr] <= bus.wr_data;
      end
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            state     <= S_RUN;
            running_q <= 1'b1;
            len_q     <= bus.seq_len;
            div_q     <= '0;
          end
        end
        S_RUN: begin
          if (cmd_stop) begin
            state     <= S_IDLE;
            running_q <= 1'b0;
            div_q     <= '0;
          end else if (cmd_pause) begin
            state     <= S_HOLD;
            running_q <= 1'b0;
          end else if (tick) begin
            div_q <= '0;
          end else begin
            div_q <= DIV_W'(div_q + DIV_W'(1));
          end
        end
        S_HOLD: begin
          if (cmd_stop) begin
            state <= S_IDLE;
            div_q <= '0;
          end else if (cmd_start) begin
            state     <= S_RUN;
            running_q <= 1'b1;
            div_q     <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          running_q <= 1'b0;
          div_q     <= '0;
        end
      endcase
    end
  end

  assign bus.index   = index_q;
  assign bus.value   = value_q;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_sequence_stepper.sv
// tb_sequence_stepper: directed and randomized stimulus for sequence_stepper,
// checked every cycle against a cycle-level behavioural model.
module tb_sequence_stepper;

  localparam int unsigned TDIV = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sequence_stepper_if bus ();

  sequence_stepper #(.TICK_DIV(TDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: 0 idle, 1 run, 2 hold.
  int         m_state;
  int         m_idx;
  int         m_len;
  int         m_cnt;
  bit         m_wrap;
  logic [3:0] m_tbl [8];

  task automatic model_reset();
    m_state = 0;
    m_idx   = 0;
    m_len   = 7;
    m_cnt   = 0;
    m_wrap  = 1'b0;
    m_tbl   = '{4'h0, 4'h3, 4'h5, 4'h9, 4'hC, 4'hF, 4'h6, 4'hA};
  endtask

  // Apply the currently driven inputs to the model for one clock edge.
  task automatic model_step();
    int  old;
    bit  adv;
    bit  down;
    old    = m_state;
    adv    = 1'b0;
    m_wrap = 1'b0;
    down   = 1'b0;
`ifdef SEQ_REVERSE_EN
    down = bus.dir;
`endif
    if (bus.stop) begin
      m_state = 0;
      m_idx   = 0;
      m_cnt   = 0;
    end else if (bus.pause) begin
      if (old == 1) m_state = 2;
    end else if (bus.start) begin
      if (old == 0) begin
        m_state = 1;
        m_len   = int'(bus.seq_len);
        m_cnt   = 0;
      end else if (old == 2) begin
        m_state = 1;
        m_cnt   = 0;
      end
    end else if (bus.step && old == 2) begin
      adv = 1'b1;
    end
    if (old == 1 && !bus.stop && !bus.pause) begin
      m_cnt++;
      if (m_cnt == int'(TDIV)) begin
        adv   = 1'b1;
        m_cnt = 0;
      end
    end
    if (adv) begin
      if (down) begin
        m_wrap = (m_idx == 0);
        m_idx  = (m_idx + m_len) % (m_len + 1);
      end else begin
        m_wrap = (m_idx == m_len);
        m_idx  = (m_idx + 1) % (m_len + 1);
      end
    end
    if (bus.wr_en && old != 1) m_tbl[bus.wr_addr] = bus.wr_data;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start   = 1'b0;
    bus.pause   = 1'b0;
    bus.stop    = 1'b0;
    bus.step    = 1'b0;
    bus.wr_en   = 1'b0;
  endtask

  // One clock edge: model update, edge, then compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("index",   8'(bus.index),   8'(m_idx));
    chk("value",   8'(bus.value),   8'(m_tbl[m_idx]));
    chk("running", 8'(bus.running), 8'(m_state == 1));
    chk("wrap",    8'(bus.wrap),    8'(m_wrap));
    clear_inputs();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    bus.dir     = 1'b0;
    bus.seq_len = 3'd7;
    bus.wr_addr = 3'd0;
    bus.wr_data = 4'd0;
    rst_n       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_index",   8'(bus.index),   8'h0);
    chk("rst_value",   8'(bus.value),   8'h0);
    chk("rst_running", 8'(bus.running), 8'h0);
    chk("rst_wrap",    8'(bus.wrap),    8'h0);

    // Full 8-entry sweep with TICK_DIV=4.
    bus.seq_len = 3'd7;
    bus.start   = 1'b1;
    cycle();
    chk("tp1_running", 8'(bus.running), 8'h1);
    cycles(4);
    chk("tp1_idx1", 8'(bus.index), 8'h1);
    chk("tp1_val1", 8'(bus.value), 8'h3);
    cycles(4);
    chk("tp1_idx2", 8'(bus.index), 8'h2);
    chk("tp1_val2", 8'(bus.value), 8'h5);
    cycles(24);
    chk("tp1_wrap_idx", 8'(bus.index), 8'h0);
    chk("tp1_wrap",     8'(bus.wrap),  8'h1);
    cycle();
    chk("tp1_wrap_once", 8'(bus.wrap), 8'h0);

    // Short sequence, seq_len=2.
    bus.stop = 1'b1;
    cycle();
    bus.seq_len = 3'd2;
    bus.start   = 1'b1;
    cycle();
    cycles(12);
    chk("tp2_idx", 8'(bus.index), 8'h0);
    chk("tp2_val", 8'(bus.value), 8'h0);
    chk("tp2_wrap", 8'(bus.wrap), 8'h1);

    // Pause, two single steps, resume.
    cycles(2);
    bus.pause = 1'b1;
    cycle();
    cycles(6);
    bus.step = 1'b1;
    cycle();
    cycle();
    bus.step = 1'b1;
    cycle();
    chk("tp3_idx", 8'(bus.index), 8'h2);
    bus.start = 1'b1;
    cycle();
    cycles(TDIV);

    // Writes in IDLE take effect, writes in RUN are dropped.
    bus.stop = 1'b1;
    cycle();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'hE;
    cycle();
    chk("tp4_idle_wr", 8'(bus.value), 8'hE);
    bus.seq_len = 3'd7;
    bus.start   = 1'b1;
    cycle();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'h7;
    cycle();
    cycles(3);
    chk("tp4_run_wr", 8'(bus.value), 8'h3);

    // stop together with pause on the tick edge.
    cycles(3);
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    cycle();
    chk("tp5_idx",  8'(bus.index),   8'h0);
    chk("tp5_run",  8'(bus.running), 8'h0);
    chk("tp5_wrap", 8'(bus.wrap),    8'h0);

    // Asynchronous reset in the middle of a run.
    bus.start = 1'b1;
    cycle();
    cycles(6);
    rst_n = 1'b0;
    #1;
    chk("arst_index",   8'(bus.index),   8'h0);
    chk("arst_value",   8'(bus.value),   8'h0);
    chk("arst_running", 8'(bus.running), 8'h0);
    chk("arst_wrap",    8'(bus.wrap),    8'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef SEQ_REVERSE_EN
    // Down-counting from index 0 wraps straight to len.
    bus.seq_len = 3'd3;
    bus.dir     = 1'b1;
    bus.start   = 1'b1;
    cycle();
    cycles(TDIV);
    chk("rev_idx3",  8'(bus.index), 8'h3);
    chk("rev_val3",  8'(bus.value), 8'h9);
    chk("rev_wrap",  8'(bus.wrap),  8'h1);
    cycles(TDIV);
    chk("rev_idx2",  8'(bus.index), 8'h2);
    cycles(TDIV);
    chk("rev_idx1",  8'(bus.index), 8'h1);
    bus.stop = 1'b1;
    cycle();
`endif

    // Randomized pulses, writes and direction.
    for (int n = 0; n < 800; n++) begin
      bus.stop    = ($urandom_range(0, 39) == 0);
      bus.pause   = ($urandom_range(0, 19) == 0);
      bus.start   = ($urandom_range(0, 9) == 0);
      bus.step    = ($urandom_range(0, 3) == 0);
      bus.dir     = 1'($urandom);
      bus.seq_len = 3'($urandom);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 3'($urandom);
      bus.wr_data = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
